// File: rtl/lcd_rom_writer_if.sv
// Bundle between lcd_rom_writer and its environment: menu handshake, phrase ROM port,
// HD44780 pins and a debug view of the writer FSM state.
interface lcd_rom_writer_if;
    // start is a one-cycle request that is honoured only while busy is low and done is low.
    // busy goes high the cycle after start is taken. done pulses for one cycle as busy falls.
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] field_p;
    logic [7:0] field_s;
    logic [7:0] field_a;
    logic [4:0] rom_addr;
    logic [7:0] rom_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    // Encoding: 0 IDLE, 1 PWR_WAIT, 2 CMD, 3 FETCH, 4 SETUP, 5 E_HIGH, 6 HOLD_WAIT, 7 DONE
    logic [2:0] dbg_state;

    modport master (
        input  start, field_p, field_s, field_a, rom_data,
        output busy, done, rom_addr, lcd_rs, lcd_rw, lcd_e, lcd_data, dbg_state
    );
    modport slave (
        output start, field_p, field_s, field_a, rom_data,
        input  busy, done, rom_addr, lcd_rs, lcd_rw, lcd_e, lcd_data, dbg_state
    );
endinterface

// File: rtl/lcd_rom_writer.sv
// Draws a 32-byte phrase ROM onto a 16x2 HD44780 LCD (8-bit mode, init once per reset).
// Optional build macro LCD_FIELD_SUBST_EN replaces the P/S/A digit positions with BCD fields.
module lcd_rom_writer #(
    parameter int unsigned PWR_WAIT_CYC = 1_000_000,
    parameter int unsigned E_PULSE_CYC  = 25,
    parameter int unsigned CMD_WAIT_CYC = 2_500,
    parameter int unsigned CLR_WAIT_CYC = 100_000
) (
    input  logic             clock,
    input  logic             reset,
    lcd_rom_writer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, PWR_WAIT, CMD, FETCH, SETUP, E_HIGH, HOLD_WAIT, DONE
    } state_e;

    localparam logic [20:0] PWR_T = 21'(PWR_WAIT_CYC);
    localparam logic [20:0] E_T   = 21'(E_PULSE_CYC);
    localparam logic [20:0] CMD_T = 21'(CMD_WAIT_CYC);
    localparam logic [20:0] CLR_T = 21'(CLR_WAIT_CYC);

    // Step numbering: 0..3 init, 4 line-1 address, 5..20 line 1, 21 line-2 address, 22..37 line 2.
    localparam logic [5:0] STEP_CLEAR = 6'd3;
    localparam logic [5:0] STEP_DRAW  = 6'd4;
    localparam logic [5:0] STEP_LINE2 = 6'd21;
    localparam logic [5:0] STEP_LAST  = 6'd37;

    state_e      state_q, state_d;
    logic [20:0] cnt_q, cnt_d;
    logic [5:0]  step_q, step_d;
    logic        init_done_q, init_done_d;
    logic [4:0]  rom_addr_q, rom_addr_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;

    logic        is_cmd;
    logic [7:0]  cmd_byte;
    logic [4:0]  byte_addr;
    logic [20:0] hold_t;
    logic [7:0]  fetched;

    always_comb begin
        cmd_byte = 8'h00;
        case (step_q)
            6'd0:       cmd_byte = 8'h38;
            6'd1:       cmd_byte = 8'h0C;
            6'd2:       cmd_byte = 8'h06;
            STEP_CLEAR: cmd_byte = 8'h01;
            STEP_DRAW:  cmd_byte = 8'h80;
            STEP_LINE2: cmd_byte = 8'hC0;
            default:    cmd_byte = 8'h00;
        endcase
    end

    assign is_cmd    = (step_q <= STEP_DRAW) || (step_q == STEP_LINE2);
    assign byte_addr = (step_q < STEP_LINE2) ? 5'(step_q - 6'd5) : 5'(step_q - 6'd6);
    assign hold_t    = (step_q == STEP_CLEAR) ? CLR_T : CMD_T;

`ifdef LCD_FIELD_SUBST_EN
    function automatic logic [7:0] bcd_char(input logic [3:0] n);
        return (n > 4'd9) ? 8'h3F : 8'h30 + {4'h0, n};
    endfunction

    always_comb begin
        fetched = bus.rom_data;
        case (rom_addr_q)
            5'd18:   fetched = bcd_char(bus.field_p[7:4]);
            5'd19:   fetched = bcd_char(bus.field_p[3:0]);
            5'd24:   fetched = bcd_char(bus.field_s[7:4]);
            5'd25:   fetched = bcd_char(bus.field_s[3:0]);
            5'd30:   fetched = bcd_char(bus.field_a[7:4]);
            5'd31:   fetched = bcd_char(bus.field_a[3:0]);
            default: fetched = bus.rom_data;
        endcase
    end
`else
    assign fetched = bus.rom_data;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            step_q      <= '0;
            init_done_q <= 1'b0;
            rom_addr_q  <= '0;
            rs_q        <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            init_done_q <= init_done_d;
            rom_addr_q  <= rom_addr_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        init_done_d = init_done_q;
        rom_addr_d  = rom_addr_q;
        rs_d        = rs_q;
        data_d      = data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d   = '0;
                    state_d = init_done_q ? CMD : PWR_WAIT;
                    step_d  = init_done_q ? STEP_DRAW : 6'd0;
                end
            end
            PWR_WAIT: begin
                cnt_d = cnt_q + 21'd1;
                if (cnt_q == PWR_T - 21'd1) begin
                    cnt_d   = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                cnt_d = '0;
                if (is_cmd) begin
                    rs_d    = 1'b0;
                    data_d  = cmd_byte;
                    state_d = SETUP;
                end else begin
                    state_d = FETCH;
                end
            end
            // Address registered on the first cycle, ROM registers it on the second, data captured on the third.
            FETCH: begin
                cnt_d = cnt_q + 21'd1;
                if (cnt_q == 21'd0) rom_addr_d = byte_addr;
                if (cnt_q == 21'd2) begin
                    rs_d    = 1'b1;
                    data_d  = fetched;
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = E_HIGH;
            end
            E_HIGH: begin
                cnt_d = cnt_q + 21'd1;
                if (cnt_q == E_T - 21'd1) begin
                    cnt_d   = '0;
                    state_d = HOLD_WAIT;
                end
            end
            HOLD_WAIT: begin
                cnt_d = cnt_q + 21'd1;
                if (cnt_q == hold_t - 21'd1) begin
                    cnt_d = '0;
                    if (step_q == STEP_CLEAR) init_done_d = 1'b1;
                    if (step_q == STEP_LAST) begin
                        state_d = DONE;
                    end else begin
                        step_d  = step_q + 6'd1;
                        state_d = CMD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = (state_q != IDLE) && (state_q != DONE);
    assign bus.done      = (state_q == DONE);
    assign bus.rom_addr  = rom_addr_q;
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_e     = (state_q == E_HIGH);
    assign bus.lcd_data  = data_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_lcd_rom_writer.sv
// Bench for lcd_rom_writer: phrase ROM model, pin-level monitor with byte scoreboard,
// fixed and randomized draws, mid-draw reset.
module tb_lcd_rom_writer;
  localparam int PWR  = 20;
  localparam int EW   = 3;
  localparam int CMDW = 5;
  localparam int CLRW = 10;
  localparam logic [2:0] HOLD_ST = 3'd6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lcd_rom_writer_if bus();

  lcd_rom_writer #(
    .PWR_WAIT_CYC(PWR), .E_PULSE_CYC(EW), .CMD_WAIT_CYC(CMDW), .CLR_WAIT_CYC(CLRW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  logic [7:0] rom [32];
  logic [7:0] fld [3];
  always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the LCD must receive, derived from the ROM image and field rules.
  logic [8:0] exp_q[$];

  function automatic logic [7:0] model_char(input int a);
    logic [3:0] nib;
`ifdef LCD_FIELD_SUBST_EN
    if (a >= 18 && (a % 6) < 2) begin
      nib = (a % 2 == 0) ? fld[(a - 18) / 6][7:4] : fld[(a - 18) / 6][3:0];
      return (nib > 9) ? 8'h3F : 8'(48 + int'(nib));
    end
`endif
    nib = 4'h0;
    return rom[a] | {4'h0, nib};
  endfunction

  task automatic build_exp(input bit with_init);
    exp_q.delete();
    if (with_init) begin
      exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
      exp_q.push_back(9'h006); exp_q.push_back(9'h001);
    end
    exp_q.push_back(9'h080);
    for (int a = 0; a < 16; a++) exp_q.push_back({1'b1, model_char(a)});
    exp_q.push_back(9'h0C0);
    for (int a = 16; a < 32; a++) exp_q.push_back({1'b1, model_char(a)});
  endtask

  // Pin monitor
  int pulses = 0, done_cnt = 0, e_len = 0, hold_len = 0;
  logic prev_e = 1'b0, tracking = 1'b0, unstable = 1'b0;
  logic [2:0] prev_st = 3'd0;
  logic [8:0] cur, prev_bus, want;
  logic [8:0] log_q[$];

  always @(negedge clock) begin
    if (reset) begin
      prev_e = 1'b0; prev_st = 3'd0; tracking = 1'b0; e_len = 0; hold_len = 0;
    end else begin
      if (bus.lcd_e && !prev_e) begin
        cur = {bus.lcd_rs, bus.lcd_data};
        pulses++;
        log_q.push_back(cur);
        tracking = 1'b1; unstable = (cur !== prev_bus); e_len = 0; hold_len = 0;
        if (exp_q.size() == 0) check("extra_pulse", 1, 0);
        else begin
          want = exp_q.pop_front();
          check("lcd_byte", cur, want);
        end
        check("lcd_rw", bus.lcd_rw, 0);
      end
      if (bus.lcd_e) e_len++;
      if (!bus.lcd_e && prev_e) check("e_high_len", e_len, EW);
      if (tracking && (bus.lcd_e || bus.dbg_state == HOLD_ST) &&
          {bus.lcd_rs, bus.lcd_data} !== cur) unstable = 1'b1;
      if (bus.dbg_state == HOLD_ST) hold_len++;
      if (tracking && prev_st == HOLD_ST && bus.dbg_state != HOLD_ST) begin
        check("hold_len", hold_len, (cur == 9'h001) ? CLRW : CMDW);
        check("bus_stable", unstable, 0);
        tracking = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_low_with_done", bus.busy, 0);
      end
      prev_e = bus.lcd_e; prev_st = bus.dbg_state; prev_bus = {bus.lcd_rs, bus.lcd_data};
    end
  end

  task automatic run_draw(input bit with_init, input int glitch_at, output int first_rise);
    int p0, d0, cyc, p_end;
    build_exp(with_init);
    p0 = pulses; d0 = done_cnt; first_rise = 0;
    @(negedge clock);
    check("busy_before_start", bus.busy, 0);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    cyc = 1;
    while (done_cnt == d0 && cyc < 3000) begin
      if (first_rise == 0 && bus.lcd_e) first_rise = cyc;
      @(negedge clock);
      bus.start = (glitch_at != 0 && cyc == glitch_at);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_seen", done_cnt != d0, 1);
    check("pulse_count", pulses - p0, with_init ? 38 : 34);
    check("exp_drained", exp_q.size(), 0);
    p_end = pulses;
    repeat (4) @(negedge clock);
    check("idle_after_done", bus.busy, 0);
    check("no_pulse_after_done", pulses - p_end, 0);
    check("single_done", done_cnt - d0, 1);
  endtask

  typedef struct {
    int         idx;
    logic [8:0] exp;
  } vec_t;
  vec_t vt[13];

  initial begin
    string l1, l2;
    int fr, p0, cyc;
    l1 = "DEFINIR AMARELO:";
    l2 = "P:XY  S:XY  A:XY";
    for (int i = 0; i < 16; i++) begin
      rom[i] = l1[i];
      rom[16 + i] = l2[i];
    end
    fld[0] = 8'h42; fld[1] = 8'h07; fld[2] = 8'hA1;
    bus.field_p = fld[0]; bus.field_s = fld[1]; bus.field_a = fld[2];
    bus.start = 1'b0;

    vt[0] = '{0, 9'h038};  vt[1] = '{1, 9'h00C};  vt[2] = '{2, 9'h006};
    vt[3] = '{3, 9'h001};  vt[4] = '{4, 9'h080};  vt[5] = '{5, 9'h144};
    vt[6] = '{20, 9'h13A}; vt[7] = '{21, 9'h0C0}; vt[8] = '{22, 9'h150};
`ifdef LCD_FIELD_SUBST_EN
    vt[9] = '{24, 9'h134}; vt[10] = '{31, 9'h137};
    vt[11] = '{36, 9'h13F}; vt[12] = '{37, 9'h131};
`else
    vt[9] = '{24, 9'h158}; vt[10] = '{31, 9'h159};
    vt[11] = '{36, 9'h158}; vt[12] = '{37, 9'h159};
`endif

    repeat (3) @(negedge clock);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_e", bus.lcd_e, 0);
    check("rst_rs", bus.lcd_rs, 0);
    check("rst_rw", bus.lcd_rw, 0);
    check("rst_data", bus.lcd_data, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    reset = 1'b0;

    // First draw: power-up wait and full init
    log_q.delete();
    run_draw(1, 0, fr);
    check("pwr_wait_before_first_e", fr > PWR, 1);
    for (int i = 0; i < 13; i++) check($sformatf("vec%0d", vt[i].idx), log_q[vt[i].idx], vt[i].exp);

    // Second draw: init skipped, a start while busy must be ignored
    log_q.delete();
    run_draw(0, 60, fr);
    check("first_byte_no_init", log_q[0], 9'h080);

    // Random ROM images, field values and stray starts
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) rom[i] = 8'($urandom_range(32, 126));
      for (int k = 0; k < 3; k++) fld[k] = 8'($urandom);
      bus.field_p = fld[0]; bus.field_s = fld[1]; bus.field_a = fld[2];
      run_draw(0, $urandom_range(10, 200), fr);
    end

    for (int i = 0; i < 16; i++) begin
      rom[i] = l1[i];
      rom[16 + i] = l2[i];
    end

    // Reset in the middle of line 2, then a fresh draw must redo power-up and init
    build_exp(0);
    p0 = pulses;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    cyc = 0;
    while (pulses - p0 < 24 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    check("reached_line2", pulses - p0 >= 24, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_e", bus.lcd_e, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rs", bus.lcd_rs, 0);
    check("mid_rst_data", bus.lcd_data, 0);
    check("mid_rst_rom_addr", bus.rom_addr, 0);
    check("mid_rst_done", bus.done, 0);
    reset = 1'b0;
    log_q.delete();
    run_draw(1, 0, fr);
    check("pwr_wait_after_reset", fr > PWR, 1);
    check("reinit_first_byte", log_q[0], 9'h038);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
